control_unit_fsm: RTL and testbench
===================================

// Module: control_unit_fsm
// PURPOSE
//  Multicycle controller sequencing Datapath: latches opcode, steps FETCH/DECODE/EXEC/MEM/WB,
//  drives every Datapath select/enable flag, and runs IN and HD handshakes. Sits beside Datapath
//  in the processor top; owns data-memory write strobe, halt status and retired-instruction count.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter instr_count
// PORTS
//  clock          in   1   single system clock, rising edge
//  reset          in   1   asynchronous, active-high
//  run            in   1   1 = leave FETCH; 0 = park in FETCH (no state change)
//  opcode         in   6   instruction[31:26] from Datapath
//  flagJB         in   1   branch-taken from Datapath (combinational)
//  in_valid       in   1   IN device has data
//  hd_ack         in   1   HD read data valid on dataFromHD
//  flagJR/flagLSR/flagRF/flagAddrRF/flagMP  out 1 each  Datapath controls
//  flagUpdateData out  3   Datapath control; 0 in this revision
//  flagPC         out  3   0 hold, 1 PC+1, 2 load newAddress
//  flagBQ         out  2   0 none, 1 BEQ, 2 BNE
//  flagMuxRF      out  3   RF write-data select (Datapath encoding)
//  dm_we          out  1   data-memory write strobe
//  in_ready       out  1   controller waiting for IN
//  out_valid      out  1   OUT register holds fresh value (1-cycle pulse)
//  hd_req         out  1   HD read request, held until hd_ack
//  halted         out  1   HALT executed
//  illegal_op     out  1   1-cycle pulse on unknown opcode
//  instr_count    out  CNT_W  retired instructions
// BEHAVIOUR
//  Reset (async): state=FETCH, op_q=0, all outputs 0, instr_count=0; hd_req drops immediately.
//  States: FETCH->DECODE (if run) ->EXEC->{MEM|WAIT_IN|WAIT_HD|WB}->WB->FETCH; HALT absorbing.
//  DECODE: op_q<=opcode. All outputs are registered Moore functions of (state, op_q).
//  Opcodes (op_q): ALU 00, LI 01, LW 02, LWR 03, SW 04, SWR 05, BEQ 06, BNE 07, J 08, JR 09,
//   IN 0A, OUT 0B, HDR 0C, NOP 0D, HALT 3F; others = illegal, behave as NOP.
//  EXEC: SW/SWR dm_we=1 one cycle (flagLSR=1 for SWR); LW/LWR ->MEM; IN ->WAIT_IN; HDR ->WAIT_HD.
//  MEM: one cycle, flagLSR=1 for LWR, DM read settles.
//  WAIT_IN: in_ready=1; in_valid&in_ready -> WB; waits indefinitely.
//  WAIT_HD: hd_req=1; hd_ack -> WB (ack same cycle as req entry allowed).
//  WB (single cycle): flagRF=1 with flagMuxRF ALU=1, LW/LWR=2, IN=3, LI=4, HDR=5;
//   flagPC=1 except J=2, JR=2 with flagJR=1, BEQ/BNE: flagBQ=1/2 and flagPC=2 if flagJB else 1;
//   OUT: out_valid=1, flagPC=1; flagMuxRF also 3 in IN WB; instr_count+=1 (wraps to 0).
//  HALT: reached from EXEC; halted=1, flagPC=0, stays until reset; instr_count includes HALT.
//  illegal_op pulses in EXEC. flagAddrRF, flagMP, flagUpdateData held 0 this revision.
//  Latency: ALU/LI/SW/branch/jump/OUT/NOP = 4 cycles; LW/LWR = 5; IN/HDR = 4 + wait cycles.
//  run=0 only checked in FETCH; in-flight instruction always completes.
//  flagBQ driven in WB only, so flagJB sampled with RDvalue/RSvalue stable.
// STRUCTURE
//  Package cpu_ctrl_pkg: opcode localparams, state enum, flagPC/flagBQ/flagMuxRF encodings.
//  One sub-module: ctrl_decode (combinational op_q+state -> next outputs); FSM/counter in top.
// TESTING
//  Reset mid-WAIT_HD (hd_req=1) -> hd_req=0 same cycle, state FETCH, instr_count=0.
//  ALU op, run=1 -> flagRF=1 & flagMuxRF=1 in cycle 4 only, flagPC=1, instr_count=1.
//  LWR -> flagLSR=1 in MEM and WB, flagMuxRF=2 in cycle 5; SWR -> dm_we one pulse cycle 3.
//  BEQ with flagJB=1 -> flagBQ=1, flagPC=2 in WB; flagJB=0 -> flagPC=1.
//  IN with in_valid low 10 cycles -> in_ready high 10 cycles, WB flagMuxRF=3 after in_valid.
//  Opcode 0x2A -> illegal_op pulse, PC+1; HALT 0x3F -> halted=1, flags stable 100 cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states,
// Datapath select encodings and the bundle of registered control outputs.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_LI   = 6'h01;
  localparam logic [5:0] OP_LW   = 6'h02;
  localparam logic [5:0] OP_LWR  = 6'h03;
  localparam logic [5:0] OP_SW   = 6'h04;
  localparam logic [5:0] OP_SWR  = 6'h05;
  localparam logic [5:0] OP_BEQ  = 6'h06;
  localparam logic [5:0] OP_BNE  = 6'h07;
  localparam logic [5:0] OP_J    = 6'h08;
  localparam logic [5:0] OP_JR   = 6'h09;
  localparam logic [5:0] OP_IN   = 6'h0A;
  localparam logic [5:0] OP_OUT  = 6'h0B;
  localparam logic [5:0] OP_HDR  = 6'h0C;
  localparam logic [5:0] OP_NOP  = 6'h0D;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [2:0] PC_HOLD = 3'd0;
  localparam logic [2:0] PC_INC  = 3'd1;
  localparam logic [2:0] PC_LOAD = 3'd2;

  localparam logic [1:0] BQ_NONE = 2'd0;
  localparam logic [1:0] BQ_BEQ  = 2'd1;
  localparam logic [1:0] BQ_BNE  = 2'd2;

  localparam logic [2:0] MUX_NONE = 3'd0;
  localparam logic [2:0] MUX_ALU  = 3'd1;
  localparam logic [2:0] MUX_DM   = 3'd2;
  localparam logic [2:0] MUX_IN   = 3'd3;
  localparam logic [2:0] MUX_IMM  = 3'd4;
  localparam logic [2:0] MUX_HD   = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WAIT_IN,
    S_WAIT_HD,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       flagJR;
    logic       flagLSR;
    logic       flagRF;
    logic       flagAddrRF;
    logic       flagMP;
    logic [2:0] flagUpdateData;
    logic [2:0] flagPC;
    logic [1:0] flagBQ;
    logic [2:0] flagMuxRF;
    logic       dmWe;
    logic       inReady;
    logic       outValid;
    logic       hdReq;
    logic       halted;
    logic       illegalOp;
  } ctrl_out_t;

  function automatic logic isLegalOp(input logic [5:0] op);
    return (op <= OP_NOP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (state, opcode) into the full control word; the
// top feeds it the next state/opcode so the outputs can be registered.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       jumpTaken_i,
  output ctrl_out_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_EXEC: begin
        ctrl_o.dmWe      = (op_i == OP_SW) || (op_i == OP_SWR);
        ctrl_o.flagLSR   = (op_i == OP_SWR);
        ctrl_o.illegalOp = !isLegalOp(op_i);
      end
      S_MEM:     ctrl_o.flagLSR = (op_i == OP_LWR);
      S_WAIT_IN: ctrl_o.inReady = 1'b1;
      S_WAIT_HD: ctrl_o.hdReq   = 1'b1;
      S_WB: begin
        ctrl_o.flagPC = PC_INC;
        case (op_i)
          OP_ALU: begin ctrl_o.flagRF = 1'b1; ctrl_o.flagMuxRF = MUX_ALU; end
          OP_LI:  begin ctrl_o.flagRF = 1'b1; ctrl_o.flagMuxRF = MUX_IMM; end
          OP_LW:  begin ctrl_o.flagRF = 1'b1; ctrl_o.flagMuxRF = MUX_DM;  end
          OP_LWR: begin
            ctrl_o.flagRF    = 1'b1;
            ctrl_o.flagMuxRF = MUX_DM;
            ctrl_o.flagLSR   = 1'b1;
          end
          OP_IN:  begin ctrl_o.flagRF = 1'b1; ctrl_o.flagMuxRF = MUX_IN; end
          OP_HDR: begin ctrl_o.flagRF = 1'b1; ctrl_o.flagMuxRF = MUX_HD; end
          // Branch outcome is taken from flagJB as the controller enters WB.
          OP_BEQ: begin
            ctrl_o.flagBQ = BQ_BEQ;
            ctrl_o.flagPC = jumpTaken_i ? PC_LOAD : PC_INC;
          end
          OP_BNE: begin
            ctrl_o.flagBQ = BQ_BNE;
            ctrl_o.flagPC = jumpTaken_i ? PC_LOAD : PC_INC;
          end
          OP_J:   ctrl_o.flagPC = PC_LOAD;
          OP_JR:  begin ctrl_o.flagPC = PC_LOAD; ctrl_o.flagJR = 1'b1; end
          OP_OUT: ctrl_o.outValid = 1'b1;
          default: ;
        endcase
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle controller: sequences FETCH/DECODE/EXEC/MEM/WB with IN and HD
// handshakes, registers every Datapath control and counts retired instructions.
module control_unit_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             flagJB,
  input  logic             in_valid,
  input  logic             hd_ack,
  output logic             flagJR,
  output logic             flagLSR,
  output logic             flagRF,
  output logic             flagAddrRF,
  output logic             flagMP,
  output logic [2:0]       flagUpdateData,
  output logic [2:0]       flagPC,
  output logic [1:0]       flagBQ,
  output logic [2:0]       flagMuxRF,
  output logic             dm_we,
  output logic             in_ready,
  output logic             out_valid,
  output logic             hd_req,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  ctrl_out_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH:  if (run) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LW, OP_LWR: state_d = S_MEM;
          OP_IN:         state_d = S_WAIT_IN;
          OP_HDR:        state_d = S_WAIT_HD;
          OP_HALT:       state_d = S_HALT;
          default:       state_d = S_WB;
        endcase
      end
      S_MEM:     state_d = S_WB;
      S_WAIT_IN: if (in_valid && ctrl_q.inReady) state_d = S_WB;
      S_WAIT_HD: if (hd_ack) state_d = S_WB;
      S_WB:      state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase

    // An instruction retires as it enters WB, or as HALT is first reached.
    count_d = count_q;
    if ((state_d == S_WB) || ((state_d == S_HALT) && (state_q != S_HALT)))
      count_d = count_q + CNT_W'(1);
  end

  ctrl_decode u_decode (
    .state_i     (state_d),
    .op_i        (op_d),
    .jumpTaken_i (flagJB),
    .ctrl_o      (ctrl_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
    end
  end

  assign flagJR         = ctrl_q.flagJR;
  assign flagLSR        = ctrl_q.flagLSR;
  assign flagRF         = ctrl_q.flagRF;
  assign flagAddrRF     = ctrl_q.flagAddrRF;
  assign flagMP         = ctrl_q.flagMP;
  assign flagUpdateData = ctrl_q.flagUpdateData;
  assign flagPC         = ctrl_q.flagPC;
  assign flagBQ         = ctrl_q.flagBQ;
  assign flagMuxRF      = ctrl_q.flagMuxRF;
  assign dm_we          = ctrl_q.dmWe;
  assign in_ready       = ctrl_q.inReady;
  assign out_valid      = ctrl_q.outValid;
  assign hd_req         = ctrl_q.hdReq;
  assign halted         = ctrl_q.halted;
  assign illegal_op     = ctrl_q.illegalOp;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed and random instruction
// streams compared cycle by cycle against a per-instruction timeline model.
module tb_control_unit_fsm;

  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             run;
  logic [5:0]       opcode;
  logic             flagJB;
  logic             in_valid;
  logic             hd_ack;
  logic             flagJR, flagLSR, flagRF, flagAddrRF, flagMP;
  logic [2:0]       flagUpdateData, flagPC, flagMuxRF;
  logic [1:0]       flagBQ;
  logic             dm_we, in_ready, out_valid, hd_req, halted, illegal_op;
  logic [CNT_W-1:0] instr_count;

  int testsRun    = 0;
  int testsFailed = 0;
  int modelCount  = 0;

  typedef struct packed {
    logic       jr, lsr, rf, addrRf, mp;
    logic [2:0] upd, pc;
    logic [1:0] bq;
    logic [2:0] mux;
    logic       we, inr, outv, hdr, halt, ill;
  } expVec_t;

  logic [21:0] obsVec;
  assign obsVec = {flagJR, flagLSR, flagRF, flagAddrRF, flagMP, flagUpdateData,
                   flagPC, flagBQ, flagMuxRF, dm_we, in_ready, out_valid,
                   hd_req, halted, illegal_op};

  control_unit_fsm #(.CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .opcode         (opcode),
    .flagJB         (flagJB),
    .in_valid       (in_valid),
    .hd_ack         (hd_ack),
    .flagJR         (flagJR),
    .flagLSR        (flagLSR),
    .flagRF         (flagRF),
    .flagAddrRF     (flagAddrRF),
    .flagMP         (flagMP),
    .flagUpdateData (flagUpdateData),
    .flagPC         (flagPC),
    .flagBQ         (flagBQ),
    .flagMuxRF      (flagMuxRF),
    .dm_we          (dm_we),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .hd_req         (hd_req),
    .halted         (halted),
    .illegal_op     (illegal_op),
    .instr_count    (instr_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    return (op <= 6'h0D) || (op == 6'h3F);
  endfunction

  function automatic logic [21:0] execModel(input logic [5:0] op);
    expVec_t e;
    e = '0;
    e.we  = (op == 6'h04) || (op == 6'h05);
    e.lsr = (op == 6'h05);
    e.ill = !isLegal(op);
    return e;
  endfunction

  function automatic logic [21:0] wbModel(input logic [5:0] op, input logic jb);
    expVec_t e;
    e = '0;
    e.pc = 3'd1;
    case (op)
      6'h00: begin e.rf = 1'b1; e.mux = 3'd1; end
      6'h01: begin e.rf = 1'b1; e.mux = 3'd4; end
      6'h02: begin e.rf = 1'b1; e.mux = 3'd2; end
      6'h03: begin e.rf = 1'b1; e.mux = 3'd2; e.lsr = 1'b1; end
      6'h06: begin e.bq = 2'd1; e.pc = jb ? 3'd2 : 3'd1; end
      6'h07: begin e.bq = 2'd2; e.pc = jb ? 3'd2 : 3'd1; end
      6'h08: e.pc = 3'd2;
      6'h09: begin e.pc = 3'd2; e.jr = 1'b1; end
      6'h0A: begin e.rf = 1'b1; e.mux = 3'd3; end
      6'h0B: e.outv = 1'b1;
      6'h0C: begin e.rf = 1'b1; e.mux = 3'd5; end
      default: ;
    endcase
    return e;
  endfunction

  // Runs one non-HALT instruction from FETCH back to FETCH, checking every cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic jb,
                               input int waitCycles, input int idleCycles);
    expVec_t e;
    run    = 1'b0;
    opcode = 6'($urandom);
    flagJB = jb;
    for (int i = 0; i < idleCycles; i++) begin
      step();
      checkOutput("park", 32'(obsVec), 32'(0));
      checkOutput("parkCount", instr_count, 32'(modelCount));
    end
    run    = 1'b1;
    opcode = op;
    step();
    checkOutput("decode", 32'(obsVec), 32'(0));
    run = 1'b0;
    step();
    opcode = 6'($urandom);
    checkOutput($sformatf("exec op=%h", op), 32'(obsVec), 32'(execModel(op)));
    if (op == 6'h02 || op == 6'h03) begin
      step();
      e = '0;
      e.lsr = (op == 6'h03);
      checkOutput("mem", 32'(obsVec), 32'(e));
    end
    if (op == 6'h0A || op == 6'h0C) begin
      for (int k = 0; k <= waitCycles; k++) begin
        step();
        e = '0;
        e.inr = (op == 6'h0A);
        e.hdr = (op == 6'h0C);
        checkOutput("wait", 32'(obsVec), 32'(e));
        if (op == 6'h0A) in_valid = (k == waitCycles);
        else             hd_ack   = (k == waitCycles);
      end
    end
    step();
    in_valid = 1'b0;
    hd_ack   = 1'b0;
    modelCount++;
    checkOutput($sformatf("wb op=%h jb=%0d", op, jb), 32'(obsVec), 32'(wbModel(op, jb)));
    checkOutput("count", instr_count, 32'(modelCount));
    step();
    checkOutput("fetch", 32'(obsVec), 32'(0));
  endtask

  initial begin
    expVec_t     e;
    logic [5:0]  op;
    int          sel;

    reset    = 1'b1;
    run      = 1'b0;
    opcode   = '0;
    flagJB   = 1'b0;
    in_valid = 1'b0;
    hd_ack   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetOut", 32'(obsVec), 32'(0));
    checkOutput("resetCount", instr_count, 32'(0));
    reset = 1'b0;

    applyStimulus(6'h00, 1'b0, 0, 2);
    applyStimulus(6'h03, 1'b0, 0, 0);
    applyStimulus(6'h05, 1'b0, 0, 1);
    applyStimulus(6'h06, 1'b1, 0, 0);
    applyStimulus(6'h06, 1'b0, 0, 0);
    applyStimulus(6'h07, 1'b1, 0, 0);
    applyStimulus(6'h0A, 1'b0, 10, 0);
    applyStimulus(6'h2A, 1'b0, 0, 0);
    applyStimulus(6'h0C, 1'b0, 0, 0);
    applyStimulus(6'h0C, 1'b1, 3, 0);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 15);
      if (sel < 14) op = 6'(sel);
      else          op = 6'($urandom_range(14, 62));
      applyStimulus(op, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                    $urandom_range(0, 2));
    end

    // Asynchronous reset while an HD request is outstanding.
    run    = 1'b1;
    opcode = 6'h0C;
    step();
    run = 1'b0;
    step();
    step();
    checkOutput("hdReqBeforeReset", 32'(hd_req), 32'(1));
    reset = 1'b1;
    #1;
    modelCount = 0;
    checkOutput("hdReqAsyncDrop", 32'(obsVec), 32'(0));
    checkOutput("countAfterReset", instr_count, 32'(0));
    @(negedge clock);
    reset = 1'b0;
    step();
    checkOutput("idleAfterReset", 32'(obsVec), 32'(0));
    applyStimulus(6'h00, 1'b0, 0, 0);

    // HALT is absorbing regardless of inputs.
    run    = 1'b1;
    opcode = 6'h3F;
    step();
    checkOutput("haltDecode", 32'(obsVec), 32'(0));
    run = 1'b0;
    step();
    checkOutput("haltExec", 32'(obsVec), 32'(0));
    step();
    modelCount++;
    e = '0;
    e.halt = 1'b1;
    checkOutput("halted", 32'(obsVec), 32'(e));
    checkOutput("haltCount", instr_count, 32'(modelCount));
    for (int i = 0; i < 100; i++) begin
      run      = 1'($urandom);
      opcode   = 6'($urandom);
      flagJB   = 1'($urandom);
      in_valid = 1'($urandom);
      hd_ack   = 1'($urandom);
      step();
      checkOutput("haltStable", 32'(obsVec), 32'(e));
      checkOutput("haltCountStable", instr_count, 32'(modelCount));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
